// File: rtl/qnigma_tcp_tx_sched_if.sv
// qnigma_tcp_tx_sched_if: descriptor type and RAM/transmit-path bus of the TCP tx scheduler
package qnigma_tcp_pkg;
  typedef struct packed {
    logic [31:0] start;
    logic [31:0] stop;
    logic [15:0] len;
    logic [7:0]  tim;
    logic [7:0]  tries;
  } tcp_pkt_t;
endpackage

interface qnigma_tcp_tx_sched_if #(parameter int D = 4);
  logic                    add;
  logic                    tick;
  logic [31:0]             rem_ack;
  qnigma_tcp_pkg::tcp_pkt_t pkt_r;
  logic [D-1:0]            ptr;
  logic                    upd;
  logic                    free;
  qnigma_tcp_pkg::tcp_pkt_t pkt_w;
  logic                    retx_req;
  qnigma_tcp_pkg::tcp_pkt_t retx_pkt;
  logic                    retx_ack;
  logic                    empty;
  logic                    fail;
  modport master (
    input  add, tick, rem_ack, pkt_r, retx_ack,
    output ptr, upd, free, pkt_w, retx_req, retx_pkt, empty, fail
  );
  modport slave (
    output add, tick, rem_ack, pkt_r, retx_ack,
    input  ptr, upd, free, pkt_w, retx_req, retx_pkt, empty, fail
  );
endinterface

// File: rtl/qnigma_tcp_tx_sched.sv
// qnigma_tcp_tx_sched: walks tx descriptors oldest-first, frees acked ones, ages and retransmits the rest
module qnigma_tcp_tx_sched
  import qnigma_tcp_pkg::*;
#(
  parameter int D         = 4,
  parameter int RTO_TICKS = 8,
  parameter int MAX_TRIES = 5
) (
  input logic                     clk,
  input logic                     rst,
  qnigma_tcp_tx_sched_if.master   bus
);
  typedef enum logic [3:0] {IDLE, READ, WAIT, CHECK, FREE, RETX, UPD, NEXT, HALT} state_t;
  state_t       state, state_n;
  logic [D-1:0] head, idx;
  logic [D:0]   cnt, left;
  logic         tick_pend, age, req, fail_r;
  logic         start, acked, timeout, tries_out;
  tcp_pkt_t     cur, w, rp, bump, rearm;
  assign start     = state == IDLE && cnt != '0;
  // modular sequence comparison: ack is at or past stop
  assign acked     = $signed(bus.rem_ack - cur.stop) >= 0;
  assign timeout   = age && (int'(cur.tim) + 1 >= RTO_TICKS);
  assign tries_out = int'(cur.tries) >= MAX_TRIES;
  always_comb begin
    bump        = cur;
    bump.tim    = cur.tim == 8'hFF ? cur.tim : cur.tim + 8'd1;
    rearm       = cur;
    rearm.tim   = '0;
    rearm.tries = cur.tries + 8'd1;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? READ : IDLE;
      READ:    state_n = WAIT;
      WAIT:    state_n = CHECK;
      CHECK:   state_n = acked ? (idx == head ? FREE : NEXT) : timeout ? RETX : age ? UPD : NEXT;
      FREE:    state_n = NEXT;
      RETX:    state_n = !req ? (tries_out ? HALT : RETX) : bus.retx_ack ? UPD : RETX;
      UPD:     state_n = NEXT;
      NEXT:    state_n = left == {{D{1'b0}}, 1'b1} ? IDLE : READ;
      default: state_n = state;
    endcase
  end
  always_comb begin
    bus.upd  = state == UPD;
    bus.free = state == FREE;
  end
  assign bus.ptr      = idx;
  assign bus.pkt_w    = w;
  assign bus.retx_req = req;
  assign bus.retx_pkt = rp;
  assign bus.empty    = cnt == '0;
  assign bus.fail     = fail_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      cnt       <= '0;
      tick_pend <= 1'b0;
      idx       <= '0;
      left      <= '0;
      age       <= 1'b0;
      cur       <= '0;
      w         <= '0;
      rp        <= '0;
      req       <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      cnt       <= cnt + (D+1)'(bus.add) - (D+1)'(bus.free);
      tick_pend <= bus.tick | (tick_pend & ~start);
      if (start) begin
        idx  <= head;
        left <= cnt;
        age  <= tick_pend;
      end
      if (state == WAIT) cur <= bus.pkt_r;
      if (state == CHECK && state_n == UPD) w <= bump;
      if (state == FREE) head <= head + 1'b1;
      if (state == RETX && !req && !tries_out) begin
        req <= 1'b1;
        rp  <= cur;
      end
      if (state == RETX && !req && tries_out) fail_r <= 1'b1;
      if (state == RETX && req && bus.retx_ack) begin
        req <= 1'b0;
        w   <= rearm;
      end
      if (state == NEXT) begin
        idx  <= idx + 1'b1;
        left <= left - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_qnigma_tcp_tx_sched.sv
// tb_qnigma_tcp_tx_sched: table-driven free/ack checks plus hand sequences for collision, retransmit and fail
module tb_qnigma_tcp_tx_sched;
  import qnigma_tcp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  qnigma_tcp_tx_sched_if #(.D(4)) bus();
  qnigma_tcp_tx_sched #(.D(4), .RTO_TICKS(2), .MAX_TRIES(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  tcp_pkt_t   ram [16];
  tcp_pkt_t   pkt_in;
  logic [3:0] wr;
  int cyc = 0, n_free = 0, n_upd = 0, n_retx = 0;
  int n_cmp = 0, n_err = 0;
  logic retx_prev = 1'b0;
  int free_ptrs[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) wr <= '0;
    else begin
      if (bus.add) begin
        ram[wr] <= pkt_in;
        wr <= wr + 4'd1;
      end
      if (bus.upd) ram[bus.ptr] <= bus.pkt_w;
    end
    bus.pkt_r <= ram[bus.ptr];
  end
  always @(posedge clk) begin
    retx_prev <= bus.retx_req;
    if (!rst) begin
      if (bus.free) begin
        n_free <= n_free + 1;
        free_ptrs.push_back(int'(bus.ptr));
      end
      if (bus.upd) n_upd <= n_upd + 1;
      if (bus.retx_req && !retx_prev) n_retx <= n_retx + 1;
    end
  end
  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] ack;
    int          frees;
    logic        emp;
  } vec_t;
  vec_t tbl[9];
  function automatic tcp_pkt_t mk(input logic [31:0] s);
    mk = '{start: s - 32'd100, stop: s, len: 16'd100, tim: 8'd0, tries: 8'd0};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add_one(input logic [31:0] s);
    @(negedge clk);
    bus.add = 1'b1;
    pkt_in = mk(s);
    @(negedge clk);
    bus.add = 1'b0;
  endtask
  task automatic pulse_tick();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask
  initial begin
    int t0, f0, u0, r0, act;
    tcp_pkt_t exp;
    tbl = '{
      '{3,  32'd100,        32'd100, 32'd250,        2,  1'b0},
      '{0,  32'd0,          32'd0,   32'd300,        1,  1'b1},
      '{1,  32'hFFFF_FFF0,  32'd0,   32'h0000_0010,  1,  1'b1},
      '{1,  32'hFFFF_FFF0,  32'd0,   32'hFFFF_FF00,  0,  1'b0},
      '{0,  32'd0,          32'd0,   32'hFFFF_FFF0,  1,  1'b1},
      '{16, 32'd1000,       32'd10,  32'd500,        0,  1'b0},
      '{0,  32'd0,          32'd0,   32'd1150,       16, 1'b1},
      '{3,  32'd2000,       32'd10,  32'd2015,       2,  1'b0},
      '{0,  32'd0,          32'd0,   32'd2020,       1,  1'b1}
    };
    bus.add = 1'b0; bus.tick = 1'b0; bus.rem_ack = '0; bus.retx_ack = 1'b0; pkt_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ptr", bus.ptr, 0);
    chk("rst_upd", bus.upd, 0);
    chk("rst_free", bus.free, 0);
    chk("rst_pkt_w", bus.pkt_w, 0);
    chk("rst_retx_req", bus.retx_req, 0);
    chk("rst_retx_pkt", bus.retx_pkt, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_fail", bus.fail, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      f0 = n_free;
      free_ptrs.delete();
      @(negedge clk);
      bus.rem_ack = tbl[i].ack;
      for (int j = 0; j < tbl[i].n; j++) begin
        @(negedge clk);
        bus.add = 1'b1;
        pkt_in = mk(tbl[i].base + tbl[i].step * j);
      end
      @(negedge clk);
      bus.add = 1'b0;
      repeat (300) @(negedge clk);
      chk($sformatf("vec%0d_frees", i), n_free - f0, tbl[i].frees);
      chk($sformatf("vec%0d_empty", i), bus.empty, tbl[i].emp);
      if (i == 6)
        for (int j = 0; j < 16; j++) begin
          act = j < free_ptrs.size() ? free_ptrs[j] : -1;
          chk($sformatf("wrap_free_ptr%0d", j), act, (5 + j) % 16);
        end
    end
    @(negedge clk);
    bus.rem_ack = 32'd5000;
    add_one(32'd3000);
    for (int k = 0; k < 60 && !bus.free; k++) @(negedge clk);
    chk("collide_free_seen", bus.free, 1);
    bus.add = 1'b1;
    pkt_in = mk(32'd3100);
    t0 = cyc;
    @(negedge clk);
    bus.add = 1'b0;
    chk("collide_empty", bus.empty, 0);
    for (int k = 0; k < 60 && !bus.free; k++) @(negedge clk);
    chk("collide_gap", cyc - t0, 6);
    repeat (10) @(negedge clk);
    chk("collide_drained", bus.empty, 1);
    add_one(32'd6000);
    repeat (10) @(negedge clk);
    u0 = n_upd;
    pulse_tick();
    repeat (30) @(negedge clk);
    chk("age_upd_count", n_upd - u0, 1);
    pulse_tick();
    for (int k = 0; k < 60 && !bus.retx_req; k++) @(negedge clk);
    chk("retx_req_high", bus.retx_req, 1);
    exp = mk(32'd6000);
    exp.tim = 8'd1;
    chk("retx_pkt", bus.retx_pkt, exp);
    u0 = n_upd;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("retx_hold%0d", k), bus.retx_req, 1);
    end
    bus.retx_ack = 1'b1;
    @(negedge clk);
    bus.retx_ack = 1'b0;
    chk("retx_req_drop", bus.retx_req, 0);
    chk("retx_upd_pulse", bus.upd, 1);
    exp.tim = 8'd0;
    exp.tries = 8'd1;
    chk("retx_pkt_w", bus.pkt_w, exp);
    chk("retx_no_early_upd", n_upd - u0, 0);
    r0 = n_retx;
    pulse_tick();
    repeat (30) @(negedge clk);
    pulse_tick();
    for (int k = 0; k < 60 && !bus.fail; k++) @(negedge clk);
    chk("fail_set", bus.fail, 1);
    chk("fail_no_retx", n_retx - r0, 0);
    u0 = n_upd; f0 = n_free; r0 = n_retx;
    bus.rem_ack = 32'd7000;
    pulse_tick();
    repeat (20) @(negedge clk);
    pulse_tick();
    repeat (50) @(negedge clk);
    chk("halt_no_upd", n_upd - u0, 0);
    chk("halt_no_free", n_free - f0, 0);
    chk("halt_no_retx", n_retx - r0, 0);
    chk("halt_fail_sticky", bus.fail, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_fail", bus.fail, 0);
    chk("rerst_empty", bus.empty, 1);
    chk("rerst_retx_req", bus.retx_req, 0);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
